sw_btn_in_port: RTL and testbench

//  CPU-readable input peripheral for the board's 16 slide switches and 5 push buttons.

---
 rtl/sw_btn_in_port_pkg.sv | 17 +
 rtl/sw_btn_in_port_if.sv | 20 ++
 rtl/sw_btn_in_port_debouncer.sv | 49 ++++
 rtl/sw_btn_in_port.sv | 107 ++++++++++
 tb/tb_sw_btn_in_port.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_btn_in_port_pkg.sv
// Shared definitions for the switch/button input port: register map and
// STAT bit positions used by the top level and by anyone decoding reads.
package sw_btn_in_port_pkg;

    // Word offsets on bus addr[3:2]
    localparam logic [1:0] IN_DATA = 2'd0;
    localparam logic [1:0] IN_EDGE = 2'd1;
    localparam logic [1:0] IN_MASK = 2'd2;
    localparam logic [1:0] IN_STAT = 2'd3;

    // STAT register bit positions
    localparam int STAT_INTR_BIT = 0;
    localparam int STAT_ANY_BIT  = 1;

    localparam int BUS_W = 32;

endpackage

// File: rtl/sw_btn_in_port_if.sv
// Data-memory bus slice seen by the switch/button port.
// Handshake: a transfer happens in any cycle where cs is high. cs&we
// commits wdata to the register at addr on the next posedge; cs&re makes
// rdata valid combinationally in the same cycle (zero wait states, there
// is no ready/stall). rdata is 0 whenever cs&re is low.
interface sw_btn_in_port_if;
    import sw_btn_in_port_pkg::*;

    logic             cs;
    logic             re;
    logic             we;
    logic [1:0]       addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;

    modport master (output cs, output re, output we, output addr, output wdata,
                    input rdata);
    modport slave  (input cs, input re, input we, input addr, input wdata,
                    output rdata);
endinterface

// File: rtl/sw_btn_in_port_debouncer.sv
// One input bit: two-flop synchroniser, tick-sampled history and the
// debounced level. db_next is exported so the top can see the rising
// edge in the same cycle the level is accepted.
module sw_btn_in_port_debouncer #(
    parameter int DB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic db,
    output logic db_next
);

    logic [1:0]            sync_q, sync_d;
    logic [DB_SAMPLES-1:0] hist_q, hist_d;
    logic                  db_q, db_d;

    // Next-state: shift the synchronised bit in on tick; accept a new
    // level only once the whole history agrees and disagrees with db.
    always_comb begin
        sync_d = {sync_q[0], din};
        hist_d = hist_q;
        db_d   = db_q;
        if (tick) begin
            hist_d = {hist_q[DB_SAMPLES-2:0], sync_q[1]};
        end
        if (hist_q == {DB_SAMPLES{~db_q}}) begin
            db_d = ~db_q;
        end
    end

    // State registers; reset discards any partially collected history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            db_q   <= db_d;
        end
    end

    assign db      = db_q;
    assign db_next = db_d;

endmodule

// File: rtl/sw_btn_in_port.sv
// Switch/button input peripheral: debounced levels, sticky rising-edge
// flags, interrupt mask and a level interrupt, readable over the bus.
module sw_btn_in_port
    import sw_btn_in_port_pkg::*;
#(
    parameter int N_SW       = 16,
    parameter int N_BTN      = 5,
    parameter int DB_TICKS   = 50000,
    parameter int DB_SAMPLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sw_btn_in_port_if.slave      bus,
    input  logic [N_SW-1:0]      sw,
    input  logic [N_BTN-1:0]     btn,
    output logic                 intr,
    input  logic                 inta
);

    localparam int N  = N_SW + N_BTN;
    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [N-1:0]  pins;
    logic [N-1:0]  db_vec, db_next_vec, rise;
    logic [N-1:0]  edge_q, edge_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  clr;
    logic          intr_q, intr_d;
    logic          wr_edge, wr_mask;
    logic [BUS_W-1:0] rdata_c;
    logic          unused_wdata;

    assign pins = {btn, sw};

    // Prescaler: wraps at DB_TICKS-1 and flags that cycle as the sample tick.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    for (genvar i = 0; i < N; i++) begin : g_db
        sw_btn_in_port_debouncer #(
            .DB_SAMPLES (DB_SAMPLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .din     (pins[i]),
            .db      (db_vec[i]),
            .db_next (db_next_vec[i])
        );
    end

    // Edge flags, mask and interrupt: a new rising edge beats any clear
    // landing on the same bit; inta clears with the mask from before any
    // concurrent mask write; intr lags the flags by one cycle.
    always_comb begin
        wr_edge = bus.cs & bus.we & (bus.addr == IN_EDGE);
        wr_mask = bus.cs & bus.we & (bus.addr == IN_MASK);
        rise    = db_next_vec & ~db_vec;
        clr     = '0;
        if (wr_edge) clr = clr | bus.wdata[N-1:0];
        if (inta)    clr = clr | mask_q;
        edge_d  = (edge_q & ~clr) | rise;
        mask_d  = wr_mask ? bus.wdata[N-1:0] : mask_q;
        intr_d  = |(edge_q & mask_q);
    end

    // Register state for prescaler, flags, mask and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            edge_q <= '0;
            mask_q <= '0;
            intr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            intr_q <= intr_d;
        end
    end

    // Zero-latency read mux; unused upper bits read as 0.
    always_comb begin
        rdata_c = '0;
        if (bus.cs && bus.re) begin
            case (bus.addr)
                IN_DATA: rdata_c[N-1:0] = db_vec;
                IN_EDGE: rdata_c[N-1:0] = edge_q;
                IN_MASK: rdata_c[N-1:0] = mask_q;
                default: begin
                    rdata_c[STAT_INTR_BIT] = intr_q;
                    rdata_c[STAT_ANY_BIT]  = |edge_q;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_c;
    assign intr         = intr_q;
    assign unused_wdata = ^bus.wdata;

endmodule

// File: tb/tb_sw_btn_in_port.sv
module tb_sw_btn_in_port;
  import sw_btn_in_port_pkg::*;

  localparam logic [31:0] NMASK = 32'h001F_FFFF;
  localparam logic [31:0] B20   = 32'h0010_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] sw;
  logic [4:0]  btn;
  logic        intr;
  logic        inta;

  sw_btn_in_port_if bus_if();

  sw_btn_in_port #(
    .N_SW(16), .N_BTN(5), .DB_TICKS(4), .DB_SAMPLES(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .sw    (sw),
    .btn   (btn),
    .intr  (intr),
    .inta  (inta)
  );

  // ---------------- reference model state ----------------
  // Stable input levels, sticky flags and mask as the programmer sees them.
  logic [31:0] exp_lvl, exp_edge, exp_mask;
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pins(input logic [31:0] v);
    sw  = v[15:0];
    btn = v[20:16];
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.re = 1'b1; bus_if.addr = a;
    @(negedge clk);
    d = bus_if.rdata;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    if (a == IN_MASK) exp_mask = d & NMASK;
    if (a == IN_EDGE) exp_edge = exp_edge & ~d;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    @(posedge clk);
    #1;
    inta = 1'b0;
    exp_edge = exp_edge & ~exp_mask;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    rd(a, got);
    check(tag, got, exp_q.pop_front());
  endtask

  // Hold a new level long enough to qualify; a 0->1 change is a new edge.
  task automatic settle(input logic [31:0] v);
    set_pins(v);
    cyc(20);
    exp_edge = exp_edge | (v & ~exp_lvl & NMASK);
    exp_lvl  = v & NMASK;
  endtask

  // A pulse of at most 8 cycles can be sampled at most twice: never accepted.
  task automatic glitch(input logic [31:0] bits, input int len);
    set_pins(exp_lvl ^ bits);
    cyc(len);
    set_pins(exp_lvl);
    cyc(20);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] st;
    cyc(2);
    st = {30'b0, |exp_edge, |(exp_edge & exp_mask)};
    check({tag, "_intr"}, {31'b0, intr}, {31'b0, st[0]});
    rd_chk({tag, "_data"}, IN_DATA, exp_lvl);
    rd_chk({tag, "_edge"}, IN_EDGE, exp_edge);
    rd_chk({tag, "_mask"}, IN_MASK, exp_mask);
    rd_chk({tag, "_stat"}, IN_STAT, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [31:0] v;
    logic [31:0] held;
    logic found;
    bus_if.cs = 0; bus_if.re = 0; bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0;
    inta = 0;
    sw = 16'hA5A5; btn = 5'h0;
    exp_lvl = 0; exp_edge = 0; exp_mask = 0;

    // 1. reset state, then A5A5 qualifies within 16 cycles
    cyc(3);
    check("rst_intr", {31'b0, intr}, 32'h0);
    for (int a = 0; a < 4; a++) rd_chk("rst_reg", 2'(a), 32'h0);
    reset = 1'b0;
    cyc(16);
    exp_lvl = 32'h0000_A5A5;
    exp_edge = 32'h0000_A5A5;
    rd_chk("t1_data", IN_DATA, 32'h0000_A5A5);
    check("t1_intr", {31'b0, intr}, 32'h0);
    wr(IN_EDGE, 32'hFFFF_FFFF);
    check_regs("t1");

    // 2. glitch rejected, steady level accepted
    settle(exp_lvl & ~32'h1);
    glitch(32'h1, 2);
    check_regs("t2_glitch");
    settle(exp_lvl | 32'h1);
    rd_chk("t2_edge1", IN_EDGE, 32'h1);
    check_regs("t2_hold");

    // 3. masked button press raises intr one cycle after the flag
    wr(IN_MASK, B20);
    bus_if.cs = 1; bus_if.re = 1; bus_if.addr = IN_EDGE;
    btn[4] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_if.rdata[20]) found = 1'b1;
    end
    check("t3_edge_seen", {31'b0, found}, 32'h1);
    check("t3_intr_lag", {31'b0, intr}, 32'h0);
    @(negedge clk);
    check("t3_intr_set", {31'b0, intr}, 32'h1);
    @(posedge clk);
    #1;
    bus_if.cs = 0; bus_if.re = 0;
    cyc(20);
    exp_lvl = exp_lvl | B20;
    exp_edge = exp_edge | B20;
    rd_chk("t3_stat", IN_STAT, 32'h3);
    pulse_inta();
    @(negedge clk);
    check("t3_intr_hold", {31'b0, intr}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_intr_clr", {31'b0, intr}, 32'h0);
    @(posedge clk);
    #1;
    check_regs("t3");
    settle(exp_lvl & ~B20);

    // 4. inta clears masked flags only; write-1 clears
    settle(exp_lvl | B20);
    check_regs("t4_set");
    pulse_inta();
    check_regs("t4_inta");
    wr(IN_EDGE, 32'h1);
    check_regs("t4_w1c");
    settle(exp_lvl & ~B20);

    // 5. set beats a simultaneous write-1 clear
    settle(exp_lvl & ~32'h8);
    wr(IN_EDGE, 32'h8);
    bus_if.cs = 1; bus_if.re = 1; bus_if.we = 1; bus_if.addr = IN_EDGE; bus_if.wdata = 32'h8;
    sw[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_if.rdata[3]) found = 1'b1;
    end
    bus_if.cs = 0; bus_if.re = 0; bus_if.we = 0;
    check("t5_set_wins", {31'b0, found}, 32'h1);
    cyc(20);
    exp_lvl = exp_lvl | 32'h8;
    exp_edge = exp_edge | 32'h8;
    check_regs("t5");

    // random traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 6))
        0, 1: settle(exp_lvl ^ ($urandom & $urandom & NMASK));
        2:    glitch($urandom & $urandom & NMASK, $urandom_range(1, 6));
        3:    wr(IN_MASK, $urandom);
        4:    wr(IN_EDGE, $urandom);
        5:    pulse_inta();
        default: begin
          v = $urandom;
          wr(v[0] ? IN_DATA : IN_STAT, $urandom);
        end
      endcase
      check_regs("rnd");
    end

    // 6. reset mid-debounce discards history
    settle(exp_lvl & ~32'h20);
    held = exp_lvl | 32'h20;
    set_pins(held);
    cyc(9);
    reset = 1'b1;
    cyc(2);
    exp_lvl = 0; exp_edge = 0; exp_mask = 0;
    check("t6_rst_intr", {31'b0, intr}, 32'h0);
    for (int a = 0; a < 4; a++) rd_chk("t6_rst_reg", 2'(a), 32'h0);
    reset = 1'b0;
    cyc(10);
    rd_chk("t6_no_early", IN_DATA, 32'h0);
    cyc(10);
    exp_lvl = held;
    exp_edge = held;
    check_regs("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
